// File: rtl/processor_pio_in_irq.sv
// Avalon-MM input PIO slave with synchroniser, per-bit edge capture
// (write-1-to-clear), interrupt mask and registered interrupt output.
module processor_pio_in_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_mux;
  logic             irq_next;
  logic             wr_en;
  logic             unused_bits;

  // Upper write-data bits are deliberately dropped when WIDTH < 32.
  assign unused_bits = ^{1'b0, writedata};

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign wr_en     = chipselect & ~write_n;

  // Metastability chain: first stage samples the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // One-cycle delayed copy of the synchronised data for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_prev <= '0;
    else          d_prev <= data_sync;
  end

  // Edge selection and write-1-to-clear decode.
  always_comb begin
    rise       = data_sync & ~d_prev;
    fall       = ~data_sync & d_prev;
    edge_event = rise | fall;
    case (EDGE_TYPE)
      0:       edge_event = rise;
      1:       edge_event = fall;
      default: edge_event = rise | fall;
    endcase
    clear_bits = '0;
    if (wr_en && address == 2'd3) clear_bits = writedata[WIDTH-1:0];
  end

  // Capture bits: a new event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~clear_bits) | edge_event;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         irq_mask <= '0;
    else if (wr_en && address == 2'd2)    irq_mask <= writedata[WIDTH-1:0];
  end

  // Read mux and interrupt source, both from current register state.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = data_sync;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
    if (IRQ_MODE == 0) irq_next = |(data_sync & irq_mask);
    else               irq_next = |(edge_capture & irq_mask);
  end

  // Registered bus and interrupt outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_next;
    end
  end

endmodule
